// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its mult/div scoreboard.
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    // Countdown must hold the longest latency minus one; one spare value keeps LAT=2^n safe.
    function automatic int unsigned mdCntWidth(int unsigned mulLat, int unsigned divLat);
        int unsigned longest;
        longest = (mulLat > divLat) ? mulLat : divLat;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/md_tracker.sv
// Background mult/div occupancy tracker: counts down the unit latency and pulses done when HI/LO land.
module md_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam int unsigned CW = mdCntWidth(MUL_LAT, DIV_LAT);
    localparam logic [CW-1:0] MulLoad = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DivLoad = CW'(DIV_LAT - 1);

    md_state_t     stateQ, stateD;
    logic [CW-1:0] cntQ, cntD;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateQ <= MD_IDLE;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        case (stateQ)
            MD_IDLE: begin
                if (start) begin
                    cntD   = is_div ? DivLoad : MulLoad;
                    stateD = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (cntQ == '0) begin
                    stateD = MD_DONE;
                end else begin
                    cntD = cntQ - 1'b1;
                end
            end
            MD_DONE: stateD = MD_IDLE;
            default: stateD = MD_IDLE;
        endcase
    end

    assign busy = (stateQ != MD_IDLE);
    assign done = (stateQ == MD_DONE);

endmodule

// File: rtl/hazard_sb.sv
// 5-stage MIPS hazard unit: forwarding, load-use/branch/md stalls, exception flush, stall counter.
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              jumpregD,
    input  logic              mdopD,
    input  logic              hiloreadD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              mdstartE,
    input  logic              mddivE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              excM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    input  logic              perf_clr,
    output logic              stallF,
    output logic              stallD,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              mdbusy,
    output logic              mddone,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic lwstall, brstall, mdstall;
    logic mdStart;
    logic [CNT_W-1:0] stallCntQ;

    function automatic logic [1:0] fwdSelE(logic [REG_AW-1:0] src, logic [REG_AW-1:0] wrM,
                                           logic wenM, logic [REG_AW-1:0] wrW, logic wenW);
        if (src != '0 && wenM && wrM == src) return FWD_MEM;
        if (src != '0 && wenW && wrW == src) return FWD_WB;
        return FWD_NONE;
    endfunction

    function automatic logic readsD(logic [REG_AW-1:0] dst, logic [REG_AW-1:0] a,
                                    logic [REG_AW-1:0] b);
        return (dst != '0) && (dst == a || dst == b);
    endfunction

    assign forwardaE = fwdSelE(rsE, writeregM, regwriteM, writeregW, regwriteW);
    assign forwardbE = fwdSelE(rtE, writeregM, regwriteM, writeregW, regwriteW);
    assign forwardaD = (rsD != '0) && regwriteM && (writeregM == rsD);
    assign forwardbD = (rtD != '0) && regwriteM && (writeregM == rtD);

    assign lwstall = memtoregE && regwriteE && readsD(writeregE, rsD, rtD);
    assign brstall = (branchD || jumpregD) &&
                     ((regwriteE && readsD(writeregE, rsD, rtD)) ||
                      (memtoregM && readsD(writeregM, rsD, rtD)));
    assign mdstall = (hiloreadD || mdopD) && (mdbusy || mdstartE);

    // An exception redirects fetch, so it overrides every stall.
    assign stallD = (lwstall || brstall || mdstall) && !excM;
    assign stallF = stallD;
    assign flushE = stallD || excM;
    assign flushD = excM;
    assign flushM = excM;

    // A start colliding with a running op is ignored; the assertion below flags it.
    assign mdStart = mdstartE && !excM && !mdbusy;

    md_tracker #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) u_md_tracker (
        .clk   (clk),
        .resetn(resetn),
        .start (mdStart),
        .is_div(mddivE),
        .busy  (mdbusy),
        .done  (mddone)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stallCntQ <= '0;
        end else if (perf_clr) begin
            stallCntQ <= '0;
        end else if (stallD && stallCntQ != '1) begin
            stallCntQ <= stallCntQ + 1'b1;
        end
    end

    assign stall_cnt = stallCntQ;

    mdIssueWhileBusy: assert property (@(posedge clk) disable iff (!resetn)
                                       !(mdstartE && mdbusy));

endmodule
